fir_stream_sequencer: RTL and testbench

//  Control FSM for the FIR engine. Clears the data RAM, accepts one input sample at a time and writes it into a circular buffer.
//  For each sample it issues tap/data RAM read addresses and MAC strobes, then holds the output beat until the consumer takes it.

---
 rtl/fir_stream_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fir_stream_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_sequencer.sv
// Control FSM for the FIR engine: clears the data RAM, writes each input sample into a
// circular buffer, walks the tap/data RAM addresses for the MAC and holds each output beat.
module fir_stream_sequencer #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 32,
   parameter int pPTR_W      = 5
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst,
   input  logic                   ap_start,
   input  logic [31:0]            data_len,
   input  logic [5:0]             tap_num,
   output logic                   ap_idle,
   output logic                   ap_done,
   output logic                   err_tlast,
   input  logic                   ss_tvalid,
   input  logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tlast,
   output logic                   ss_tready,
   output logic                   data_EN,
   output logic [3:0]             data_WE,
   output logic [pADDR_WIDTH-1:0] data_A,
   output logic [pDATA_WIDTH-1:0] data_Di,
   output logic                   tap_EN,
   output logic [pADDR_WIDTH-1:0] tap_A,
   output logic                   mac_en,
   output logic                   mac_clr,
   output logic                   sm_tvalid,
   input  logic                   sm_tready,
   output logic                   sm_tlast
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_WAIT_IN, S_CALC, S_DRAIN, S_OUT, S_DONE
   } state_t;

   state_t            state, state_nx;
   logic [31:0]       len_r, ntap_r, cnt_r, out_cnt, in_cnt;
   logic [pPTR_W-1:0] wptr;
   logic              mac_en_p1, mac_clr_p1, err_r;
   logic              last_clr, last_tap, last_beat, last_in;
   logic [31:0]       tap_clamped;

   function automatic logic [pADDR_WIDTH-1:0] byte_addr(input logic [pPTR_W-1:0] idx);
      return pADDR_WIDTH'({idx, 2'b00});
   endfunction

   assign last_clr  = (cnt_r == 32'(Tape_Num - 1));
   assign last_tap  = (cnt_r == ntap_r - 32'd1);
   assign last_beat = (out_cnt == len_r - 32'd1);
   assign last_in   = (in_cnt == len_r - 32'd1);
   // Zero or oversize tap counts fall back to the full RAM depth.
   assign tap_clamped = (tap_num == 6'd0 || 32'(tap_num) > 32'(Tape_Num)) ?
                        32'(Tape_Num) : 32'(tap_num);

   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (ap_start) state_nx = (data_len == 32'd0) ? S_DONE : S_CLEAR;
         S_CLEAR:   if (last_clr) state_nx = S_WAIT_IN;
         S_WAIT_IN: if (ss_tvalid) state_nx = S_CALC;
         S_CALC:    if (last_tap) state_nx = S_DRAIN;
         S_DRAIN:   state_nx = S_OUT;
         S_OUT:     if (sm_tready) state_nx = last_beat ? S_DONE : S_WAIT_IN;
         S_DONE:    state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         len_r      <= '0;
         ntap_r     <= '0;
         cnt_r      <= '0;
         out_cnt    <= '0;
         in_cnt     <= '0;
         wptr       <= '0;
         err_r      <= 1'b0;
         mac_en_p1  <= 1'b0;
         mac_clr_p1 <= 1'b0;
      end else begin
         // p1: BRAM outputs are valid one cycle after each CALC address
         mac_en_p1  <= (state == S_CALC);
         mac_clr_p1 <= (state == S_CALC) && (cnt_r == 32'd0);
         case (state)
            S_IDLE: if (ap_start) begin
               len_r   <= data_len;
               ntap_r  <= tap_clamped;
               err_r   <= 1'b0;
               cnt_r   <= '0;
               out_cnt <= '0;
               in_cnt  <= '0;
               wptr    <= '0;
            end
            S_CLEAR: begin
               cnt_r <= last_clr ? 32'd0 : cnt_r + 32'd1;
               if (last_clr) wptr <= '0;
            end
            S_WAIT_IN: if (ss_tvalid) begin
               cnt_r  <= '0;
               in_cnt <= in_cnt + 32'd1;
               if (ss_tlast != last_in) err_r <= 1'b1;
            end
            S_CALC: cnt_r <= cnt_r + 32'd1;
            S_OUT: if (sm_tready) begin
               out_cnt <= out_cnt + 32'd1;
               wptr    <= wptr + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ap_idle   = 1'b0;
      ap_done   = 1'b0;
      ss_tready = 1'b0;
      data_EN   = 1'b0;
      data_WE   = 4'h0;
      data_A    = '0;
      data_Di   = '0;
      tap_EN    = 1'b0;
      tap_A     = '0;
      sm_tvalid = 1'b0;
      sm_tlast  = 1'b0;
      case (state)
         S_IDLE: ap_idle = 1'b1;
         S_CLEAR: begin
            data_EN = 1'b1;
            data_WE = 4'hF;
            data_A  = byte_addr(cnt_r[pPTR_W-1:0]);
         end
         S_WAIT_IN: begin
            ss_tready = 1'b1;
            if (ss_tvalid) begin
               data_EN = 1'b1;
               data_WE = 4'hF;
               data_A  = byte_addr(wptr);
               data_Di = ss_tdata;
            end
         end
         S_CALC: begin
            // Newest sample pairs with tap 0; the pointer difference wraps with the buffer.
            tap_EN  = 1'b1;
            data_EN = 1'b1;
            tap_A   = byte_addr(cnt_r[pPTR_W-1:0]);
            data_A  = byte_addr(wptr - cnt_r[pPTR_W-1:0]);
         end
         S_OUT: begin
            sm_tvalid = 1'b1;
            sm_tlast  = last_beat;
         end
         S_DONE: ap_done = 1'b1;
         default: ;
      endcase
   end

   assign mac_en    = mac_en_p1;
   assign mac_clr   = mac_clr_p1;
   assign err_tlast = err_r;

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Bench for fir_stream_sequencer: BRAM/MAC plant models plus a cycle timeline model of
// the expected sequencing and an FIR sum reference for every output beat.
module tb_fir_stream_sequencer;
   localparam int AW   = 12;
   localparam int DW   = 32;
   localparam int TN   = 32;
   localparam int PW   = 5;
   localparam int MAXC = 40000;
   localparam int INF  = 32'h7fffffff;

   logic          clk = 1'b0, rst = 1'b0;
   logic          ap_start = 1'b0;
   logic [31:0]   data_len = '0;
   logic [5:0]    tap_num = '0;
   logic          ss_tvalid = 1'b0, ss_tlast = 1'b0, sm_tready = 1'b0;
   logic [DW-1:0] ss_tdata = '0;
   logic          ap_idle, ap_done, err_tlast, ss_tready, data_EN, tap_EN;
   logic          mac_en, mac_clr, sm_tvalid, sm_tlast;
   logic [3:0]    data_WE;
   logic [AW-1:0] data_A, tap_A;
   logic [DW-1:0] data_Di;

   fir_stream_sequencer #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(TN), .pPTR_W(PW)) dut (
      .axis_clk(clk), .axis_rst(rst), .ap_start(ap_start), .data_len(data_len),
      .tap_num(tap_num), .ap_idle(ap_idle), .ap_done(ap_done), .err_tlast(err_tlast),
      .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
      .data_EN(data_EN), .data_WE(data_WE), .data_A(data_A), .data_Di(data_Di),
      .tap_EN(tap_EN), .tap_A(tap_A), .mac_en(mac_en), .mac_clr(mac_clr),
      .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast)
   );

   always #5 clk = ~clk;

   int n_total = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // BRAM and MAC plant
   logic [31:0] dram [TN];
   logic [31:0] tram [TN];
   logic [31:0] drd = '0, trd = '0, acc = '0;

   always @(posedge clk) begin
      if (data_EN) begin
         if (data_WE == 4'hF) dram[data_A[PW+1:2]] <= data_Di;
         drd <= dram[data_A[PW+1:2]];
      end
      if (tap_EN) trd <= tram[tap_A[PW+1:2]];
      if (mac_en) acc <= mac_clr ? trd * drd : acc + trd * drd;
   end

   // Timeline model
   int          cyc = 0;
   int          sch_kind [MAXC];
   int          sch_idx  [MAXC];
   bit          sch_mac  [MAXC];
   bit          sch_clr  [MAXC];
   bit          busy = 0, exp_err = 0, prev_valid = 0;
   int          ready_from = INF, out_from = INF, done_cyc = -1, hs_cyc = 0;
   int          run_len = 0, run_n = TN, in_idx = 0, out_idx = 0, cur_w = 0;
   int          clr_cnt = 0, done_cnt = 0;
   logic [31:0] xs[$];
   int          wa_q[$], lat_q[$];
   logic [31:0] src_q[$], out_q[$];

   function automatic logic [31:0] fir_ref(input int n);
      logic [31:0] s;
      s = '0;
      for (int k = 0; k < run_n; k++)
         if (n - k >= 0 && n - k < xs.size()) s = s + tram[k] * xs[n - k];
      return s;
   endfunction

   initial begin
      forever begin : mon
         bit hs_in, hs_out, e_ready, e_valid;
         int kind, idx;
         @(negedge clk);
         if (rst) begin
            chk("rst_ap_idle", ap_idle, 1);
            chk("rst_ap_done", ap_done, 0);
            chk("rst_ss_tready", ss_tready, 0);
            chk("rst_sm_tvalid", sm_tvalid, 0);
            chk("rst_mac_en", mac_en, 0);
            chk("rst_data_WE", data_WE, 0);
            chk("rst_err_tlast", err_tlast, 0);
            busy = 0; exp_err = 0; prev_valid = 0;
            ready_from = INF; out_from = INF; done_cyc = -1;
            for (int c = cyc + 1; c < MAXC; c++) begin
               sch_kind[c] = 0; sch_mac[c] = 0; sch_clr[c] = 0;
            end
         end else begin
            hs_in   = ss_tvalid && ss_tready;
            hs_out  = sm_tvalid && sm_tready;
            e_ready = busy && (cyc >= ready_from);
            e_valid = busy && (cyc >= out_from);
            kind    = sch_kind[cyc];
            idx     = sch_idx[cyc];
            chk("ap_idle", ap_idle, !busy);
            chk("ap_done", ap_done, cyc == done_cyc);
            chk("ss_tready", ss_tready, e_ready);
            chk("sm_tvalid", sm_tvalid, e_valid);
            chk("sm_tlast", sm_tlast, e_valid && (out_idx == run_len - 1));
            chk("err_tlast", err_tlast, exp_err);
            chk("mac_en", mac_en, sch_mac[cyc]);
            chk("mac_clr", mac_clr, sch_clr[cyc]);
            chk("tap_EN", tap_EN, kind == 2);
            if (kind == 2) chk("tap_A", tap_A, 4 * idx);
            if (hs_in) begin
               chk("wr_EN", data_EN, 1);
               chk("wr_WE", data_WE, 4'hF);
               chk("wr_A", data_A, 4 * (in_idx % TN));
               chk("wr_Di", data_Di, ss_tdata);
            end else if (kind == 1) begin
               chk("clr_EN", data_EN, 1);
               chk("clr_WE", data_WE, 4'hF);
               chk("clr_A", data_A, 4 * idx);
               chk("clr_Di", data_Di, 0);
            end else if (kind == 2) begin
               chk("rd_EN", data_EN, 1);
               chk("rd_WE", data_WE, 0);
               chk("rd_A", data_A, 4 * ((cur_w - idx + TN) % TN));
            end else begin
               chk("idle_EN", data_EN, 0);
               chk("idle_WE", data_WE, 0);
            end
            if (data_WE == 4'hF && !hs_in) clr_cnt++;
            if (sm_tvalid && !prev_valid) lat_q.push_back(cyc - hs_cyc);
            prev_valid = sm_tvalid;
            if (hs_in) begin
               xs.push_back(ss_tdata);
               wa_q.push_back(int'(data_A));
               if (ss_tlast != (in_idx == run_len - 1)) exp_err = 1;
               cur_w = in_idx % TN;
               for (int k = 0; k < run_n; k++) begin
                  sch_kind[cyc + 1 + k] = 2;
                  sch_idx[cyc + 1 + k]  = k;
                  sch_mac[cyc + 2 + k]  = 1;
               end
               sch_clr[cyc + 2] = 1;
               out_from   = cyc + run_n + 2;
               ready_from = INF;
               hs_cyc     = cyc;
               in_idx++;
            end
            if (hs_out) begin
               chk("y", acc, fir_ref(out_idx));
               out_idx++;
               out_from = INF;
               if (out_idx >= run_len) done_cyc = cyc + 1;
               else ready_from = cyc + 1;
            end
            if (ap_done) done_cnt++;
            if (cyc == done_cyc) busy = 0;
            else if (ap_start && !busy) begin
               busy = 1;
               run_len = int'(data_len);
               run_n = (tap_num == 0 || tap_num > TN) ? TN : int'(tap_num);
               exp_err = 0; in_idx = 0; out_idx = 0;
               xs.delete(); wa_q.delete(); lat_q.delete();
               clr_cnt = 0; done_cnt = 0; out_from = INF;
               if (data_len == 0) begin
                  done_cyc = cyc + 1; ready_from = INF;
               end else begin
                  for (int i = 0; i < TN; i++) begin
                     sch_kind[cyc + 1 + i] = 1;
                     sch_idx[cyc + 1 + i]  = i;
                  end
                  ready_from = cyc + TN + 1;
               end
            end
         end
         cyc++;
      end
   end

   initial begin
      repeat (MAXC - 100) @(negedge clk);
      $display("FAIL watchdog: cycles=%0d limit=%0d", cyc, MAXC - 100);
      $fatal(1, "bench stopped by watchdog");
   end

   task automatic send_sample(input logic [31:0] d, input bit last);
      int n; bit ok;
      ss_tvalid = 1; ss_tdata = d; ss_tlast = last;
      n = 0; ok = 0;
      while (!ok && n < 3000) begin
         @(negedge clk); ok = ss_tready;
         @(posedge clk); #1; n++;
      end
      chk("src_wait", ok, 1);
      ss_tvalid = 0; ss_tlast = 0;
   endtask

   task automatic take_output(input int stall, input bit pre, output logic [31:0] v);
      int n; bit seen;
      sm_tready = pre; n = 0; seen = 0;
      while (!seen && n < 3000) begin
         @(negedge clk); seen = sm_tvalid;
         if (!seen) begin @(posedge clk); #1; n++; end
      end
      chk("sink_wait", seen, 1);
      if (pre) begin
         v = acc;
         @(posedge clk); #1;
      end else begin
         repeat (stall + 1) begin @(posedge clk); #1; end
         sm_tready = 1;
         @(negedge clk); v = acc;
         @(posedge clk); #1;
      end
      sm_tready = 0;
   endtask

   task automatic run(input int len, input int tn, input int bad_idx, input int stall,
                      input bit rnd_sink, input bit poke);
      int n;
      out_q.delete();
      @(posedge clk); #1;
      data_len = len; tap_num = 6'(tn); ap_start = 1;
      @(posedge clk); #1;
      ap_start = 0;
      fork
         begin
            for (int i = 0; i < len; i++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               send_sample(src_q[i], (i == len - 1) ^ (i == bad_idx));
            end
         end
         begin
            for (int j = 0; j < len; j++) begin
               logic [31:0] v;
               if (rnd_sink) take_output($urandom_range(0, 4), 1'($urandom_range(0, 1)), v);
               else          take_output(stall, 1'b0, v);
               out_q.push_back(v);
            end
         end
         begin
            if (poke) begin
               repeat (100) begin @(posedge clk); #1; end
               data_len = 5; tap_num = 9; ap_start = 1;
               @(posedge clk); #1;
               ap_start = 0;
            end
         end
      join
      n = 0;
      while (done_cnt == 0 && n < 60) begin @(negedge clk); #1; n++; end
      repeat (2) begin @(negedge clk); #1; end
      chk("run_done_pulses", done_cnt, 1);
      chk("run_idle", ap_idle, 1);
   endtask

   initial begin
      int len, tn, bad;
      for (int k = 0; k < TN; k++) begin
         tram[k] = 32'(k + 1);
         dram[k] = $urandom;
      end
      #1 rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // 32 taps, three samples, 5-cycle output stall; taps are 1..32
      src_q = '{32'd5, 32'd7, 32'd11};
      run(3, 32, -1, 5, 0, 0);
      chk("t3_count", out_q.size(), 3);
      if (out_q.size() == 3) begin
         chk("t3_y0", out_q[0], 5);
         chk("t3_y1", out_q[1], 17);
         chk("t3_y2", out_q[2], 40);
      end
      chk("t2_clear_writes", clr_cnt, 32);
      chk("t3_latency", lat_q.size() > 0 ? lat_q[0] : -1, 34);
      chk("t3_wr_addr2", wa_q.size() > 2 ? wa_q[2] : -1, 8);
      chk("t3_err", err_tlast, 0);

      // reset asserted in the middle of CALC
      @(posedge clk); #1;
      data_len = 2; tap_num = 8; ap_start = 1;
      @(posedge clk); #1;
      ap_start = 0;
      send_sample(32'h55, 1'b0);
      @(posedge clk); #1;
      chk("t1_in_calc", tap_EN, 1);
      rst = 1;
      @(negedge clk);
      chk("t1_ap_idle", ap_idle, 1);
      chk("t1_ss_tready", ss_tready, 0);
      chk("t1_sm_tvalid", sm_tvalid, 0);
      chk("t1_mac_en", mac_en, 0);
      chk("t1_data_WE", data_WE, 0);
      chk("t1_tap_EN", tap_EN, 0);
      @(posedge clk); #1;
      rst = 0;

      // 33 samples through 4 taps: write pointer wraps; a stray ap_start mid-run is ignored
      for (int k = 0; k < TN; k++) tram[k] = $urandom_range(0, 255);
      src_q.delete();
      for (int i = 0; i < 33; i++) src_q.push_back($urandom_range(0, 65535));
      run(33, 4, -1, 0, 1, 1);
      chk("t5_count", out_q.size(), 33);
      chk("t5_wrap_addr", wa_q.size() > 32 ? wa_q[32] : -1, 0);
      chk("t5_latency", lat_q.size() > 0 ? lat_q[0] : -1, 6);
      chk("t5_err", err_tlast, 0);

      // early tlast on sample 2, tap_num 0 means 32 taps
      src_q.delete();
      for (int i = 0; i < 3; i++) src_q.push_back($urandom_range(0, 65535));
      run(3, 0, 1, 2, 0, 0);
      chk("t6_err", err_tlast, 1);
      chk("t6_count", out_q.size(), 3);
      chk("t6_latency", lat_q.size() > 0 ? lat_q[0] : -1, 34);

      // empty run goes straight to DONE and clears the error flag
      run(0, 5, -1, 0, 0, 0);
      chk("len0_err_cleared", err_tlast, 0);
      chk("len0_no_clear", clr_cnt, 0);

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < TN; k++) tram[k] = $urandom_range(0, 255);
         len = $urandom_range(1, 40);
         tn  = $urandom_range(0, 63);
         bad = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
         src_q.delete();
         for (int i = 0; i < len; i++) src_q.push_back($urandom_range(0, 65535));
         run(len, tn, bad, 0, 1, 0);
         chk("rnd_count", out_q.size(), len);
         chk("rnd_err", err_tlast, bad >= 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
